// File: rtl/la_pkg.sv
// Shared types for the logic-analyser sample/trigger block: FSM encoding,
// trigger-mode codes and the sample-divider helper.
package la_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ARMED   = 2'd1,
    ST_CAPTURE = 2'd2,
    ST_DONE    = 2'd3
  } la_state_t;

  localparam logic [1:0] TRIG_LOW  = 2'b00;
  localparam logic [1:0] TRIG_HIGH = 2'b01;
  localparam logic [1:0] TRIG_FALL = 2'b10;
  localparam logic [1:0] TRIG_RISE = 2'b11;

  // Divider count width; cfg tops out at 15, so 2^15-1 must fit.
  localparam int DIV_W = 16;

  // Terminal count of the divider for a given period exponent.
  function automatic logic [DIV_W-1:0] div_last(input logic [3:0] cfg);
    return (DIV_W'(1) << cfg) - DIV_W'(1);
  endfunction

endpackage

// File: rtl/la_sample_trigger_if.sv
// Write port towards the capture FIFO. The trigger block drives the
// strobe and data; the FIFO side reports back when it is full.
interface la_sample_trigger_if #(
  parameter int INPUT_WIDTH = 6
);
  logic                   wr_en;
  logic [INPUT_WIDTH-1:0] wr_data;
  logic                   wr_full;

  modport master (output wr_en, output wr_data, input wr_full);
  modport slave  (input wr_en, input wr_data, output wr_full);
endinterface

// File: rtl/la_sample_div.sv
// Sample-period divider: one-cycle strobe every 2^cfg clk cycles.
// Held at zero while clr is high so a new capture starts on a clean phase.
module la_sample_div
  import la_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       clr,
  input  logic [3:0] cfg,
  output logic       strobe
);

  logic [DIV_W-1:0] cnt;

  assign strobe = (cnt == div_last(cfg));

  // Free-running count that wraps at the terminal value or on clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                cnt <= '0;
    else if (clr || strobe) cnt <= '0;
    else                    cnt <= cnt + DIV_W'(1);
  end

endmodule

// File: rtl/la_sample_trigger.sv
// Logic-analyser sample/trigger engine. Waits for a trigger condition on
// one probe channel, then pushes sample_num samples into a FIFO at the
// configured sample rate. Configuration is latched at start so inputs may
// change freely while a capture runs.
module la_sample_trigger
  import la_pkg::*;
#(
  parameter int INPUT_WIDTH = 6,
  parameter int CNT_WIDTH   = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   sample_run,
  input  logic [3:0]             sample_clk_cfg,
  input  logic [CNT_WIDTH-1:0]   sample_num,
  input  logic [1:0]             triger_type,
  input  logic [2:0]             trigger_channel,
  input  logic [INPUT_WIDTH-1:0] din,
  la_sample_trigger_if.master    fifo,
  output logic                   start_posedge,
  output logic                   triggered,
  output logic                   busy,
  output logic                   done,
  output logic                   overflow
);

  // Synchronizers: din two deep, sample_run three deep so the edge
  // detector compares two already-settled stages.
  logic [1:0][INPUT_WIDTH-1:0] din_sync;
  logic [2:0]                  run_sync;
  logic [INPUT_WIDTH-1:0]      din_s;
  logic                        run_lvl;
  logic                        run_rise;

  assign din_s    = din_sync[1];
  assign run_lvl  = run_sync[1];
  assign run_rise = run_sync[1] & ~run_sync[2];

  // Latched configuration.
  logic [3:0]             cfg_q;
  logic [CNT_WIDTH-1:0]   num_q;
  logic [1:0]             type_q;
  logic [2:0]             ch_q;

  // Trigger history and sample counter.
  logic [INPUT_WIDTH-1:0] prev_q;
  logic                   prev_vld;
  logic [CNT_WIDTH-1:0]   cnt_q;

  la_state_t state, state_nx;
  logic      strobe;
  logic      hit;
  logic      start;
  logic      capture;
  logic      last;

  assign busy = (state != ST_IDLE);
  // cnt_q indexes the sample being taken; the trigger sample is index 0.
  assign last = (cnt_q == num_q - CNT_WIDTH'(1));

  la_sample_div u_div (
    .clk    (clk),
    .rst    (rst),
    .clr    (state == ST_IDLE),
    .cfg    (cfg_q),
    .strobe (strobe)
  );

  // Input synchronizer shift registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      din_sync <= '0;
      run_sync <= '0;
    end else begin
      din_sync <= {din_sync[0], din};
      run_sync <= {run_sync[1:0], sample_run};
    end
  end

  // Trigger condition on the selected channel; out-of-range channel fires at once.
  always_comb begin
    logic cur_bit, old_bit;
    cur_bit = 1'b0;
    old_bit = 1'b0;
    hit     = 1'b0;
    for (int i = 0; i < INPUT_WIDTH; i++) begin
      if (int'(ch_q) == i) begin
        cur_bit = din_s[i];
        old_bit = prev_q[i];
      end
    end
    case (type_q)
      TRIG_LOW:  hit = ~cur_bit;
      TRIG_HIGH: hit = cur_bit;
      TRIG_FALL: hit = prev_vld & old_bit & ~cur_bit;
      default:   hit = prev_vld & ~old_bit & cur_bit;
    endcase
    if (int'(ch_q) >= INPUT_WIDTH) hit = 1'b1;
  end

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nx;
  end

  // FSM next state plus the start / capture decisions for this cycle.
  always_comb begin
    state_nx = state;
    start    = 1'b0;
    capture  = 1'b0;
    case (state)
      ST_IDLE: begin
        if (run_rise) begin
          start    = 1'b1;
          state_nx = (sample_num == '0) ? ST_DONE : ST_ARMED;
        end
      end
      ST_ARMED: begin
        if (!run_lvl) begin
          state_nx = ST_IDLE;
        end else if (strobe && hit) begin
          capture  = 1'b1;
          state_nx = last ? ST_DONE : ST_CAPTURE;
        end
      end
      ST_CAPTURE: begin
        if (!run_lvl) begin
          state_nx = ST_IDLE;
        end else if (strobe) begin
          capture = 1'b1;
          if (last) state_nx = ST_DONE;
        end
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  // Configuration latch, sample counter and edge-mode history.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cfg_q    <= '0;
      num_q    <= '0;
      type_q   <= '0;
      ch_q     <= '0;
      cnt_q    <= '0;
      prev_q   <= '0;
      prev_vld <= 1'b0;
    end else if (start) begin
      cfg_q    <= sample_clk_cfg;
      num_q    <= sample_num;
      type_q   <= triger_type;
      ch_q     <= trigger_channel;
      cnt_q    <= '0;
      prev_vld <= 1'b0;
    end else begin
      if (capture && !last) cnt_q <= cnt_q + CNT_WIDTH'(1);
      // First strobe in ARMED only primes the history for edge modes.
      if (state == ST_ARMED && run_lvl && strobe) begin
        prev_q   <= din_s;
        prev_vld <= 1'b1;
      end
    end
  end

  // FIFO write: one cycle after the strobe; a full FIFO drops the sample.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fifo.wr_en   <= 1'b0;
      fifo.wr_data <= '0;
    end else begin
      fifo.wr_en <= capture & ~fifo.wr_full;
      if (capture) fifo.wr_data <= din_s;
    end
  end

  // Status outputs: start/done pulses, trigger flag, sticky overflow.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      start_posedge <= 1'b0;
      done          <= 1'b0;
      triggered     <= 1'b0;
      overflow      <= 1'b0;
    end else begin
      start_posedge <= start;
      done          <= (state == ST_DONE);
      if (state_nx == ST_IDLE) triggered <= 1'b0;
      else if (capture)        triggered <= 1'b1;
      if (start)                         overflow <= 1'b0;
      else if (capture && fifo.wr_full)  overflow <= 1'b1;
    end
  end

endmodule

// File: tb/tb_la_sample_trigger.sv
// Directed bench for la_sample_trigger: trigger modes, rate divider,
// FIFO-full drop, abort, empty capture and asynchronous reset.
module tb_la_sample_trigger;
  import la_pkg::*;

  localparam int IW = 6;
  localparam int CW = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic          sample_run;
  logic [3:0]    sample_clk_cfg;
  logic [CW-1:0] sample_num;
  logic [1:0]    triger_type;
  logic [2:0]    trigger_channel;
  logic [IW-1:0] din;
  logic          start_posedge, triggered, busy, done, overflow;

  la_sample_trigger_if #(.INPUT_WIDTH(IW)) fifo_if ();

  la_sample_trigger #(.INPUT_WIDTH(IW), .CNT_WIDTH(CW)) dut (
    .clk             (clk),
    .rst             (rst),
    .sample_run      (sample_run),
    .sample_clk_cfg  (sample_clk_cfg),
    .sample_num      (sample_num),
    .triger_type     (triger_type),
    .trigger_channel (trigger_channel),
    .din             (din),
    .fifo            (fifo_if),
    .start_posedge   (start_posedge),
    .triggered       (triggered),
    .busy            (busy),
    .done            (done),
    .overflow        (overflow)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Monitor state, updated once per cycle by step().
  int            cyc = 0;
  int            wr_n, first_wr, last_wr, done_n, done_cyc, st_n, st_cyc, trig_bad;
  logic [IW-1:0] first_data;

  task automatic chk(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic mon_clr();
    wr_n = 0; first_wr = 0; last_wr = 0; done_n = 0; done_cyc = 0;
    st_n = 0; st_cyc = 0; trig_bad = 0; first_data = '0;
  endtask

  // Advance one clock and sample outputs 1ns after the edge.
  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
    if (fifo_if.wr_en) begin
      wr_n++;
      if (wr_n == 1) begin
        first_wr   = cyc;
        first_data = fifo_if.wr_data;
      end
      last_wr = cyc;
      if (!triggered) trig_bad++;
    end
    if (done) begin
      done_n++;
      done_cyc = cyc;
    end
    if (start_posedge) begin
      st_n++;
      st_cyc = cyc;
    end
  endtask

  task automatic arm(input logic [3:0] cfg, input logic [1:0] typ,
                     input logic [2:0] ch, input int num);
    sample_clk_cfg  = cfg;
    triger_type     = typ;
    trigger_channel = ch;
    sample_num      = CW'(num);
    sample_run      = 1'b1;
  endtask

  task automatic wait_start(input string tag);
    int n = 0;
    while (st_n == 0 && n < 20) begin
      step();
      n++;
    end
    chk({tag, "_start"}, st_n, 1);
  endtask

  task automatic wait_done(input string tag, input int bound);
    int n = 0;
    while (done_n == 0 && n < bound) begin
      step();
      n++;
    end
    chk({tag, "_done"}, done_n, 1);
  endtask

  task automatic stop_run();
    sample_run = 1'b0;
    repeat (4) step();
  endtask

  initial begin
    int a;
    rst = 1'b1; sample_run = 1'b0; din = '0; fifo_if.wr_full = 1'b0;
    sample_clk_cfg = '0; sample_num = '0; triger_type = '0; trigger_channel = '0;
    mon_clr();
    repeat (3) step();
    chk("rst_busy",   int'(busy), 0);
    chk("rst_wr_en",  int'(fifo_if.wr_en), 0);
    chk("rst_start",  int'(start_posedge), 0);
    chk("rst_done",   int'(done), 0);
    chk("rst_trig",   int'(triggered), 0);
    chk("rst_ovf",    int'(overflow), 0);
    rst = 1'b0;
    repeat (2) step();

    // Rising edge on ch0, every cycle, 4 samples; config edits after start ignored.
    mon_clr();
    arm(4'd0, TRIG_RISE, 3'd0, 4);
    wait_start("t1");
    chk("t1_busy", int'(busy), 1);
    sample_num = 1; triger_type = TRIG_LOW;
    repeat (10) step();
    chk("t1_no_early_wr", wr_n, 0);
    din = 6'b000001;
    a = cyc;
    wait_done("t1", 30);
    chk("t1_wr_n",     wr_n, 4);
    chk("t1_latency",  first_wr - a, 3);
    chk("t1_consec",   last_wr - first_wr, 3);
    chk("t1_data0",    int'(first_data[0]), 1);
    chk("t1_done_gap", done_cyc - last_wr, 1);
    chk("t1_trig",     trig_bad, 0);
    chk("t1_idle",     int'(busy), 0);
    stop_run();
    din = '0;

    // Immediate trigger, 8-cycle sample period, 3 samples.
    mon_clr();
    din = 6'b101010;
    arm(4'd3, TRIG_HIGH, 3'd7, 3);
    wait_start("t2");
    wait_done("t2", 60);
    chk("t2_wr_n",     wr_n, 3);
    chk("t2_first",    first_wr - st_cyc, 8);
    chk("t2_spacing",  last_wr - first_wr, 16);
    chk("t2_data",     int'(first_data), 6'b101010);
    chk("t2_trig",     trig_bad, 0);
    chk("t2_done_gap", done_cyc - last_wr, 1);
    stop_run();

    // FIFO full during the 2nd and 3rd captures of 5.
    mon_clr();
    din = 6'h15;
    arm(4'd0, TRIG_HIGH, 3'd7, 5);
    wait_start("t3");
    step();
    fifo_if.wr_full = 1'b1;
    step();
    step();
    fifo_if.wr_full = 1'b0;
    wait_done("t3", 20);
    chk("t3_wr_n",     wr_n, 3);
    chk("t3_ovf",      int'(overflow), 1);
    chk("t3_done_cyc", done_cyc - st_cyc, 6);
    stop_run();
    chk("t3_ovf_sticky", int'(overflow), 1);

    // Abort after 2 of 10 samples.
    mon_clr();
    arm(4'd0, TRIG_HIGH, 3'd7, 10);
    wait_start("t4");
    chk("t4_ovf_clr", int'(overflow), 0);
    step();
    step();
    chk("t4_wr2", wr_n, 2);
    sample_run = 1'b0;
    repeat (4) step();
    chk("t4_busy",   int'(busy), 0);
    chk("t4_wr_tot", wr_n, 4);
    repeat (8) step();
    chk("t4_no_wr",   wr_n, 4);
    chk("t4_no_done", done_n, 0);
    chk("t4_trig",    int'(triggered), 0);

    // Zero-length capture.
    mon_clr();
    arm(4'd0, TRIG_HIGH, 3'd7, 0);
    wait_start("t5");
    chk("t5_busy",  int'(busy), 1);
    chk("t5_done0", int'(done), 0);
    step();
    chk("t5_done", int'(done), 1);
    chk("t5_wr_n", wr_n, 0);
    chk("t5_idle", int'(busy), 0);
    stop_run();

    // Low level on ch2, cfg=1, single sample.
    mon_clr();
    din = 6'b000100;
    arm(4'd1, TRIG_LOW, 3'd2, 1);
    wait_start("t6");
    repeat (8) step();
    chk("t6_wait", wr_n, 0);
    din = 6'b110000;
    wait_done("t6", 20);
    chk("t6_wr_n", wr_n, 1);
    chk("t6_data", int'(first_data), 6'b110000);
    chk("t6_done_gap", done_cyc - last_wr, 1);
    stop_run();

    // Reset while ARMED (rising edge that never comes).
    mon_clr();
    din = '0;
    arm(4'd0, TRIG_RISE, 3'd0, 4);
    wait_start("t7");
    repeat (3) step();
    chk("t7_busy", int'(busy), 1);
    #2 rst = 1'b1;
    #1;
    chk("t7_rst_busy", int'(busy), 0);
    sample_run = 1'b0;
    repeat (2) step();
    rst = 1'b0;
    repeat (3) step();

    // Reset mid-capture with overflow and triggered set.
    mon_clr();
    fifo_if.wr_full = 1'b1;
    arm(4'd0, TRIG_HIGH, 3'd7, 50);
    wait_start("t8");
    repeat (3) step();
    chk("t8_ovf",  int'(overflow), 1);
    chk("t8_trig", int'(triggered), 1);
    #2 rst = 1'b1;
    #1;
    chk("t8_rst_busy", int'(busy), 0);
    chk("t8_rst_trig", int'(triggered), 0);
    chk("t8_rst_ovf",  int'(overflow), 0);
    chk("t8_rst_wr",   int'(fifo_if.wr_en), 0);
    chk("t8_rst_done", int'(done), 0);
    sample_run = 1'b0;
    fifo_if.wr_full = 1'b0;
    repeat (2) step();
    rst = 1'b0;
    mon_clr();
    repeat (5) step();
    chk("t8_quiet", st_n, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
